// File: rtl/vmicro16_uart_rx_apb.sv
// APB slave UART receiver: 8N1 deserialiser feeding an RX FIFO, with DATA/STATUS registers and an irq.
// Latency: a byte reaches the FIFO on the cycle after its stop-bit sample, 2 synchroniser cycles after the line.
// Backpressure: none on the serial line; a frame that arrives while the FIFO is full is dropped and OVR is set.
module vmicro16_uart_rx_apb #(
  parameter int BUS_WIDTH    = 16,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          S_PADDR,
  input  logic                 S_PWRITE,
  input  logic                 S_PSELx,
  input  logic                 S_PENABLE,
  input  logic [BUS_WIDTH-1:0] S_PWDATA,
  output logic [BUS_WIDTH-1:0] S_PRDATA,
  output logic                 S_PREADY,
  input  logic                 rx_wire,
  output logic                 irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   FILL_MAX = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rx_s1, rx_s2;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wptr, rptr, wptr_nxt, rptr_nxt, count;
  logic          empty, full, push, pop;
  logic          ovr, ferr;
  logic          stop_smp, set_ovr, set_ferr, clr_ovr, clr_ferr;
  logic          access, rd_data_acc;
  logic [15:0]   status;
  logic [7:0]    head;

  // Two-flop synchroniser on the serial input; idles high so reset looks like a quiet line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx_wire;
      rx_s2 <= rx_s1;
    end
  end

  // Frame receiver: start-bit validation at mid-bit, then one sample per bit period
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s2) state <= START;
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s2 ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_MAX) begin
            cnt   <= '0;
            shreg <= {rx_s2, shreg[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_MAX) begin
            cnt   <= '0;
            state <= rx_s2 ? IDLE : WAIT_HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          // A break keeps us here so it yields exactly one FERR
          if (rx_s2) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus decode and frame-completion events
  assign access      = S_PSELx & S_PENABLE;
  assign S_PREADY    = access;
  assign rd_data_acc = access & ~S_PWRITE & ~S_PADDR[0];
  assign clr_ovr     = access & S_PWRITE & S_PADDR[0] & S_PWDATA[2];
  assign clr_ferr    = access & S_PWRITE & S_PADDR[0] & S_PWDATA[3];

  assign count    = wptr - rptr;
  assign empty    = (wptr == rptr);
  assign full     = (count == FILL_MAX);
  assign head     = mem[rptr[AW-1:0]];
  assign pop      = rd_data_acc & ~empty;
  assign stop_smp = (state == STOP) && (cnt == CNT_MAX);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign push     = stop_smp & rx_s2 & (~full | pop);
  assign set_ovr  = stop_smp & rx_s2 & full & ~pop;
  assign set_ferr = stop_smp & ~rx_s2;
  assign wptr_nxt = wptr + (AW + 1)'(push);
  assign rptr_nxt = rptr + (AW + 1)'(pop);

  // FIFO storage; contents need no reset because empty reads are masked
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= shreg;
  end

  // FIFO pointers, sticky error flags and irq, all updated on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      ovr  <= 1'b0;
      ferr <= 1'b0;
      irq  <= 1'b0;
    end else begin
      wptr <= wptr_nxt;
      rptr <= rptr_nxt;
      ovr  <= (ovr & ~clr_ovr) | set_ovr;
      ferr <= (ferr & ~clr_ferr) | set_ferr;
      irq  <= (wptr_nxt != rptr_nxt);
    end
  end

  assign status = {8'(count), 4'h0, ferr, ovr, full, ~empty};

  // Read mux: zero unless this slave is selected for a read
  always_comb begin
    S_PRDATA = '0;
    if (S_PSELx && !S_PWRITE) begin
      if (S_PADDR[0]) S_PRDATA = BUS_WIDTH'(status);
      else if (!empty) S_PRDATA = BUS_WIDTH'(head);
    end
  end

  logic unused_bits;
  assign unused_bits = ^{S_PADDR[15:1], S_PWDATA};

endmodule

// File: tb/tb_vmicro16_uart_rx_apb.sv
module tb_vmicro16_uart_rx_apb;
  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] paddr;
  logic        pwrite, psel, penable;
  logic [15:0] pwdata;
  logic [15:0] prdata;
  logic        pready;
  logic        rx;
  logic        irq;

  int n_total = 0;
  int n_pass  = 0;

  vmicro16_uart_rx_apb #(.BUS_WIDTH(16), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .S_PADDR(paddr), .S_PWRITE(pwrite), .S_PSELx(psel), .S_PENABLE(penable),
    .S_PWDATA(pwdata), .S_PRDATA(prdata), .S_PREADY(pready),
    .rx_wire(rx), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Two-phase APB read; returns data and PREADY seen in setup and access phases
  task automatic apb_read(input logic [15:0] addr, output logic [15:0] data,
                          output logic rdy_setup, output logic rdy_access);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    rdy_setup = pready;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    data = prdata;
    rdy_access = pready;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic apb_write(input logic [15:0] addr, input logic [15:0] data,
                           output logic [15:0] rd_seen);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    rd_seen = prdata;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // 8N1 frame, LSB first; rst_bit >= 0 pulses reset in the middle of that data bit
  task automatic send_byte(input logic [7:0] b, input int rst_bit);
    rx = 1'b0; idle_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == rst_bit) begin
        idle_cycles(CPB / 2);
        reset = 1'b0; idle_cycles(3);
        reset = 1'b1; idle_cycles(CPB - CPB / 2 - 3);
      end else begin
        idle_cycles(CPB);
      end
    end
    rx = 1'b1; idle_cycles(CPB);
  endtask

  logic [15:0] d;
  logic        r0, r1;

  initial begin
    reset = 1'b0; rx = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    idle_cycles(5);
    check("rst_irq", irq, 0);
    check("rst_prdata", prdata, 0);
    check("rst_pready", pready, 0);
    reset = 1'b1;
    idle_cycles(3);

    apb_read(16'h1, d, r0, r1);
    check("idle_status", d, 16'h0000);
    check("pready_setup", r0, 0);
    check("pready_access", r1, 1);
    check("prdata_unsel", prdata, 0);
    apb_read(16'h0, d, r0, r1);
    check("empty_data", d, 16'h0000);

    // Single byte
    send_byte(8'hA5, -1);
    idle_cycles(4);
    apb_read(16'h1, d, r0, r1);
    check("a5_status", d, 16'h0101);
    check("a5_irq", irq, 1);
    apb_write(16'h0, 16'h00FF, d);
    check("write_prdata", d, 16'h0000);
    apb_read(16'h0, d, r0, r1);
    check("a5_data", d, 16'h00A5);
    check("a5_irq_clr", irq, 0);
    apb_read(16'h1, d, r0, r1);
    check("a5_status_after", d, 16'h0000);

    // Glitch then a real frame
    rx = 1'b0; idle_cycles(4);
    rx = 1'b1; idle_cycles(3 * CPB);
    apb_read(16'h1, d, r0, r1);
    check("glitch_status", d, 16'h0000);
    send_byte(8'h3C, -1);
    idle_cycles(4);
    apb_read(16'h0, d, r0, r1);
    check("3c_data", d, 16'h003C);

    // Overrun: nine frames into eight entries
    for (int i = 1; i <= 9; i++) send_byte(8'(i), -1);
    idle_cycles(4);
    apb_read(16'h1, d, r0, r1);
    check("ovr_status", d, 16'h0807);
    check("ovr_irq", irq, 1);
    for (int i = 1; i <= 8; i++) begin
      apb_read(16'h0, d, r0, r1);
      check($sformatf("ovr_data%0d", i), d, 32'(i));
    end
    apb_write(16'h1, 16'h0004, d);
    apb_read(16'h1, d, r0, r1);
    check("ovr_cleared", d, 16'h0000);

    // Break: line low for 20 bit times
    rx = 1'b0; idle_cycles(20 * CPB);
    apb_read(16'h1, d, r0, r1);
    check("break_status", d, 16'h0008);
    rx = 1'b1; idle_cycles(2 * CPB);
    send_byte(8'h5A, -1);
    idle_cycles(4);
    apb_read(16'h1, d, r0, r1);
    check("break_5a_status", d, 16'h0109);
    apb_read(16'h0, d, r0, r1);
    check("break_5a_data", d, 16'h005A);
    apb_write(16'h1, 16'h0008, d);
    apb_read(16'h1, d, r0, r1);
    check("ferr_cleared", d, 16'h0000);

    // Reset in the middle of a frame
    send_byte(8'hFF, 4);
    idle_cycles(2 * CPB);
    apb_read(16'h1, d, r0, r1);
    check("midrst_status", d, 16'h0000);
    check("midrst_irq", irq, 0);
    send_byte(8'h81, -1);
    idle_cycles(4);
    apb_read(16'h0, d, r0, r1);
    check("81_data", d, 16'h0081);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
